// File: rtl/axis_pl_to_ps_serializer.sv
// rtl/axis_pl_to_ps_serializer.sv - round-robin multi-channel AXI-Stream width down-converter with channel tag and fixed-length tlast
module axis_pl_to_ps_serializer #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int NUM_CH    = 2,
  parameter int PKT_BEATS = 256,
  parameter int FLUSH_BIT = 0,
  localparam int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH*IN_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_CH-1:0]           s_axis_tvalid,
  output logic [NUM_CH-1:0]           s_axis_tready,
  input  logic [NUM_CH-1:0]           ch_enable,
  output logic [OUT_WIDTH-1:0]        m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [CH_BITS-1:0]          m_axis_tuser,
  input  logic [15:0]                 gpio_ctrl
);

  localparam int RATIO    = IN_WIDTH / OUT_WIDTH;
  localparam int SL_BITS  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CNT_BITS = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [SL_BITS-1:0]  LAST_SLICE = SL_BITS'(RATIO - 1);
  localparam logic [CNT_BITS-1:0] LAST_BEAT  = CNT_BITS'(PKT_BEATS - 1);

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  state_t                state_q;
  logic [IN_WIDTH-1:0]   buf_q;
  logic [SL_BITS-1:0]    slice_q;
  logic [CH_BITS-1:0]    rr_ptr_q;
  logic [CNT_BITS-1:0]   beat_cnt_q;
  logic [OUT_WIDTH-1:0]  tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [CH_BITS-1:0]    tuser_q;

  logic                  flush;
  logic                  out_hs;
  logic                  last_slice;
  logic                  load_ok;
  logic [NUM_CH-1:0]     req_rot;
  logic                  grant_vld;
  int                    grant_off;
  logic [CH_BITS-1:0]    grant;
  logic [CH_BITS-1:0]    grant_nxt;
  logic                  in_hs;
  logic [IN_WIDTH-1:0]   in_word;
  logic [SL_BITS-1:0]    slice_d;
  logic [OUT_WIDTH-1:0]  slice_data_d;
  logic [CNT_BITS-1:0]   beat_cnt_d;
  logic                  gpio_unused;

  assign gpio_unused = ^gpio_ctrl;
  assign flush       = gpio_ctrl[FLUSH_BIT];
  assign out_hs      = tvalid_q && m_axis_tready;
  assign last_slice  = (slice_q == LAST_SLICE);
  // A new word may enter when idle or when the final slice leaves this cycle
  assign load_ok     = (state_q == EMPTY) || (out_hs && last_slice);

  // Requests rotated so that bit 0 is the channel at rr_ptr
  assign req_rot = NUM_CH'({s_axis_tvalid & ch_enable, s_axis_tvalid & ch_enable} >> rr_ptr_q);

  // Round-robin search: lowest rotated offset with a live request wins
  always_comb begin
    grant_vld = 1'b0;
    grant_off = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_vld = 1'b1;
        grant_off = i;
      end
    end
    grant     = CH_BITS'((int'(rr_ptr_q) + grant_off) % NUM_CH);
    grant_nxt = CH_BITS'((int'(rr_ptr_q) + grant_off + 1) % NUM_CH);
  end

  // Reset and flush both block acceptance so no word is lost into a cleared buffer
  assign in_hs         = rst && !flush && load_ok && grant_vld;
  assign s_axis_tready = in_hs ? (NUM_CH'(1) << grant) : '0;
  assign in_word       = IN_WIDTH'(s_axis_tdata >> (int'(grant) * IN_WIDTH));
  assign slice_d       = slice_q + 1'b1;
  assign slice_data_d  = OUT_WIDTH'(buf_q >> (int'(slice_d) * OUT_WIDTH));
  assign beat_cnt_d    = !out_hs ? beat_cnt_q :
                         (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;

  // Buffer/slice FSM with registered output beat; flush outranks every handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      buf_q      <= '0;
      slice_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= '0;
    end else if (flush) begin
      state_q    <= EMPTY;
      slice_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (in_hs) begin
        state_q  <= SEND;
        buf_q    <= in_word;
        slice_q  <= '0;
        tuser_q  <= grant;
        rr_ptr_q <= grant_nxt;
        tdata_q  <= in_word[OUT_WIDTH-1:0];
        tvalid_q <= 1'b1;
        tlast_q  <= (beat_cnt_d == LAST_BEAT);
      end else if (out_hs) begin
        if (last_slice) begin
          state_q  <= EMPTY;
          tvalid_q <= 1'b0;
        end else begin
          slice_q  <= slice_d;
          tdata_q  <= slice_data_d;
          tlast_q  <= (beat_cnt_d == LAST_BEAT);
        end
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule
